int_mult_pipe_wrapper: RTL

//  Pipelined, parametrised integer multiply/MAC unit for the shared APU cluster.

---
 rtl/int_mult_pipe_wrapper.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/int_mult_pipe_wrapper.sv
// -----------------------------------------------------------------------------
// int_mult_pipe_wrapper
//
// Pipelined integer multiply / multiply-accumulate unit. It takes one
// operation per cycle on an En_i/Ready_o handshake and returns results in
// accept order on a Valid_o/Ack_i handshake. Empty stages (bubbles) collapse
// under backpressure, so the pipeline holds exactly PIPE_STAGES operations.
//
// The whole result is computed from the request operands and registered into
// stage 0. The later stages carry the finished result, tag and status toward
// the output. This keeps PIPE_STAGES=1 legal without a special case.
//
// Ports
//   clk_i     in   1           clock, rising edge
//   rst_i     in   1           synchronous reset, active-high
//   En_i      in   1           request valid
//   Op_i      in   OP_WIDTH    0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MAC,
//                              5 MSU, others illegal
//   OpA_i     in   DATA_WIDTH  operand A
//   OpB_i     in   DATA_WIDTH  operand B
//   OpC_i     in   DATA_WIDTH  accumulator operand C
//   Tag_i     in   TAG_WIDTH   request tag
//   Ready_o   out  1           request accepted this cycle if En_i=1
//   Res_o     out  DATA_WIDTH  result (0 when Valid_o=0)
//   Tag_o     out  TAG_WIDTH   tag of the result (0 when Valid_o=0)
//   Status_o  out  2           [0] illegal op, [1] always 0
//   Valid_o   out  1           result valid
//   Ack_i     in   1           consumer takes the result
// -----------------------------------------------------------------------------
module int_mult_pipe_wrapper #(
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 4,
  parameter int PIPE_STAGES = 2,
  parameter int OP_WIDTH    = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  En_i,
  input  logic [OP_WIDTH-1:0]   Op_i,
  input  logic [DATA_WIDTH-1:0] OpA_i,
  input  logic [DATA_WIDTH-1:0] OpB_i,
  input  logic [DATA_WIDTH-1:0] OpC_i,
  input  logic [TAG_WIDTH-1:0]  Tag_i,
  output logic                  Ready_o,
  output logic [DATA_WIDTH-1:0] Res_o,
  output logic [TAG_WIDTH-1:0]  Tag_o,
  output logic [1:0]            Status_o,
  output logic                  Valid_o,
  input  logic                  Ack_i
);

  localparam int DW = DATA_WIDTH;
  localparam int S  = PIPE_STAGES;

  localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_MAC    = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_MSU    = OP_WIDTH'(5);

  typedef struct packed {
    logic [DW-1:0]        res;
    logic [TAG_WIDTH-1:0] tag;
    logic                 illegal;
  } stage_t;

  // ---------------------------------------------------------------------------
  // Arithmetic
  // ---------------------------------------------------------------------------
  // A single 2*DW multiplier serves every op. The operands are sign- or
  // zero-extended to 2*DW bits as the op demands. The low 2*DW bits of the
  // product are then exact for the signed, mixed and unsigned cases alike.
  logic            a_signed;
  logic            b_signed;
  logic [2*DW-1:0] a_ext;
  logic [2*DW-1:0] b_ext;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   prod_lo;
  logic [DW-1:0]   prod_hi;
  stage_t          stage_d;

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path
    // leaves it unassigned and no latch is inferred.
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (Op_i)
      OP_MULH: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default:   ;
    endcase
  end

  assign a_ext   = {{DW{a_signed & OpA_i[DW-1]}}, OpA_i};
  assign b_ext   = {{DW{b_signed & OpB_i[DW-1]}}, OpB_i};
  assign prod    = a_ext * b_ext;
  assign prod_lo = prod[DW-1:0];
  assign prod_hi = prod[2*DW-1:DW];

  always_comb begin
    stage_d.res     = '0;
    stage_d.tag     = Tag_i;
    stage_d.illegal = 1'b0;
    case (Op_i)
      OP_MUL:    stage_d.res = prod_lo;
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  stage_d.res = prod_hi;
      OP_MAC:    stage_d.res = prod_lo + OpC_i;
      OP_MSU:    stage_d.res = OpC_i - prod_lo;
      default:   stage_d.illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  // capture[k]: stage k takes new contents this cycle. Stage k does so when it
  // is empty, or when its occupant moves on. The last stage empties on Ack_i.
  // This reduces to "Ack_i, or any empty stage at k or later". A single
  // running OR walks from the output back to stage 0 and computes it.
  logic [S-1:0] valid_q;
  stage_t       stage_q [S];
  logic [S-1:0] capture;
  logic         accept;

  always_comb begin
    logic go;
    capture = '0;
    go      = Ack_i;
    for (int k = S - 1; k >= 0; k--) begin
      go         = go | ~valid_q[k];
      capture[k] = go;
    end
  end

  // Ready_o depends combinationally on Ack_i through capture[0]. A full
  // pipeline can accept and pop in the same cycle.
  assign Ready_o = ~rst_i & capture[0];
  assign accept  = En_i & Ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      // NOTE: the data registers are cleared together with the valid bits.
      // Nothing from an in-flight operation survives a reset.
      for (int k = 0; k < S; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      // NOTE: all state uses non-blocking assignments. Each stage then reads
      // its neighbour's pre-edge value, whatever order the stages are written.
      if (capture[0]) begin
        valid_q[0] <= accept;
        if (accept) begin
          stage_q[0] <= stage_d;
        end
      end
      for (int k = 1; k < S; k++) begin
        if (capture[k]) begin
          valid_q[k] <= valid_q[k-1];
          stage_q[k] <= stage_q[k-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // When a bubble moves forward it still copies stale data along. Gating the
  // outputs with the valid bit keeps them at 0 whenever no result is present.
  assign Valid_o  = valid_q[S-1];
  assign Res_o    = Valid_o ? stage_q[S-1].res : '0;
  assign Tag_o    = Valid_o ? stage_q[S-1].tag : '0;
  assign Status_o = {1'b0, Valid_o & stage_q[S-1].illegal};

endmodule
